counter_mod_nbit: RTL and testbench
===================================

// Module: counter_mod_nbit
// PURPOSE
//  Parametrised up/down counter with programmable modulus, variable step, load,
//  and three count modes: wrap, saturate, one-shot.
//  Emits a registered terminal-count pulse for cascading and timer use.
//  One-shot mode runs a small FSM with busy/done status.
//  Drop-in successor for simple enable/load/up_down counters in timer, PWM and
//  sequencing logic.
// PARAMETERS
//  WIDTH   8  count, data and limit width in bits
//  STEP_W  4  step increment width in bits
// PORTS
//  clk      in   1       single clock; all state updates on posedge
//  reset    in   1       synchronous, active-high reset
//  enable   in   1       advance count by step this cycle
//  load     in   1       load data into count
//  data     in   WIDTH   load value
//  up_down  in   1       1 = count up, 0 = count down
//  step     in   STEP_W  increment magnitude; 0 = no change
//  limit    in   WIDTH   inclusive upper bound; count range is 0..limit
//  mode     in   2       00 wrap, 01 saturate, 10 one-shot, 11 reserved (= wrap)
//  start    in   1       one-shot arm/restart
//  count    out  WIDTH   current count (registered)
//  tc       out  1       one-cycle terminal-count pulse (registered)
//  busy     out  1       one-shot FSM in RUN
//  done     out  1       one-shot FSM in DONE
// BEHAVIOUR
//  - Reset (sync, at posedge with reset=1): count=0, tc=0, busy=0, done=0, FSM=IDLE.
//    Reset overrides all other inputs.
//  - Priority below reset: load > start > enable.
//  - Latency: every update is visible one cycle after the sampling edge.
//  - tc defaults to 0 each cycle; it is 1 only for the cycle after a boundary event.
//  - load: count <= min(data, limit); tc=0; FSM state is unchanged.
//  - Arithmetic is done in WIDTH+1 bits; no silent truncation.
//  - Boundary event, up:   count + step > limit.
//  - Boundary event, down: step > count.
//  - Out of range: if count > limit when an enabled step occurs (limit was lowered),
//    count <= limit in every mode, with no tc.
//  - step=0: count is held, no tc, no FSM transition.
//  - Wrap mode:
//    - Normal step: count +/- step.
//    - Up boundary: count <= 0, tc=1.
//    - Down boundary: count <= limit, tc=1 (residue is discarded).
//  - Saturate mode:
//    - Normal step: count +/- step.
//    - Boundary: count clamps to limit (up) or 0 (down).
//    - tc=1 only if the clamp changes count; holding at the rail gives no tc.
//  - One-shot FSM, states IDLE / RUN / DONE:
//    - IDLE: enable is ignored. start -> RUN, count <= (up_down ? 0 : limit).
//    - RUN: busy=1. An enabled step updates count as in saturate mode.
//      A boundary event clamps count, tc=1, -> DONE.
//    - DONE: done=1, count frozen, enable ignored. start -> RUN, reinitialised as from IDLE.
//    - start while in RUN restarts the count (reinitialise, stay in RUN).
//  - Mode change: if mode leaves one-shot, the FSM returns to IDLE next cycle;
//    busy and done clear; count is kept.
//  - limit=0: every enabled nonzero step is a boundary event. Wrap mode then pulses
//    tc every enabled cycle with count=0.
//  - Max-range corners (limit = 2^WIDTH-1, count near the rails) must not overflow.
// TESTING
//  - Reset: assert reset mid-count (count=5, mode=10, FSM in RUN)
//    -> next cycle count=0, tc=0, busy=0, done=0.
//  - Wrap up (WIDTH=8, limit=9, step=3, up, count=0): enable for 4 cycles
//    -> 3,6,9,0; tc=1 only with count=0.
//  - Wrap down (limit=9, step=2, down, count=1): enable once -> count=9, tc=1.
//    Next enable -> count=7, tc=0.
//  - Saturate (limit=200, step=15, up, load data=190): enable x3
//    -> 200 (tc=1), 200 (tc=0), 200 (tc=0).
//    Load data=250 -> count=200.
//  - One-shot (limit=4, step=1, up): start, then enable x5
//    -> busy 1; count 1,2,3,4; 5th enable gives tc=1, done=1, count=4.
//    Further enable: no change. start -> count=0, busy=1.
//  - Priority: load=1, start=1, enable=1 in the same cycle, data=7
//    -> count=7, FSM unchanged, tc=0.
//    Lower limit to 3 with count=7, then enable -> count=3, tc=0.

Source files
------------

// File: rtl/counter_mod_nbit.sv
// counter_mod_nbit: up/down counter bounded 0..limit with step, load, wrap/saturate/one-shot modes; in clk reset enable load data up_down step limit mode start, out count tc busy done
module counter_mod_nbit #(
  parameter int WIDTH = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [WIDTH-1:0]  data,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic [1:0]        mode,
  input  logic              start,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              busy,
  output logic              done
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state, state_n;
  logic [WIDTH-1:0] count_n, stepped, rail;
  logic [WIDTH:0] ext_step, sum;
  logic tc_n, one_shot, sat, bnd;
  assign ext_step = {{(WIDTH+1-STEP_W){1'b0}}, step};
  assign sum = {1'b0, count} + ext_step;
  assign bnd = up_down ? sum > {1'b0, limit} : ext_step > {1'b0, count};
  assign stepped = up_down ? count + ext_step[WIDTH-1:0] : count - ext_step[WIDTH-1:0];
  assign rail = up_down ? limit : '0;
  assign one_shot = mode == 2'b10;
  assign sat = mode == 2'b01;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    count_n = count;
    tc_n = 1'b0;
    state_n = one_shot ? state : IDLE;
    if (load)
      count_n = data > limit ? limit : data;
    else if (one_shot && start) begin
      count_n = up_down ? '0 : limit;
      state_n = RUN;
    end else if (enable && step != '0 && (!one_shot || state == RUN)) begin
      if (count > limit)
        count_n = limit;
      else if (!bnd)
        count_n = stepped;
      else if (one_shot) begin
        count_n = rail;
        tc_n = 1'b1;
        state_n = DONE;
      end else if (sat) begin
        count_n = rail;
        tc_n = count != rail;
      end else begin
        count_n = up_down ? '0 : limit;
        tc_n = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tc <= 1'b0;
      state <= IDLE;
    end else begin
      count <= count_n;
      tc <= tc_n;
      state <= state_n;
    end
  end
endmodule

// File: tb/tb_counter_mod_nbit.sv
// tb_counter_mod_nbit: scoreboard bench for counter_mod_nbit against an arithmetic reference model
module tb_counter_mod_nbit;
  localparam int WIDTH = 8;
  localparam int STEP_W = 4;
  typedef struct {
    int c;
    bit t;
    bit b;
    bit d;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic load = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic up_down = 1'b1;
  logic [STEP_W-1:0] step = '0;
  logic [WIDTH-1:0] limit = '0;
  logic [1:0] mode = 2'b00;
  logic start = 1'b0;
  logic [WIDTH-1:0] count;
  logic tc, busy, done;
  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int m_c = 0;
  int m_ph = 0;
  bit m_t = 0;
  counter_mod_nbit #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .data(data),
    .up_down(up_down), .step(step), .limit(limit), .mode(mode), .start(start),
    .count(count), .tc(tc), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic model();
    int lim, s, t, r;
    bit os;
    lim = int'(limit);
    s = int'(step);
    os = mode == 2'b10;
    m_t = 0;
    if (reset) begin
      m_c = 0;
      m_ph = 0;
      return;
    end
    r = m_ph;
    if (!os) m_ph = 0;
    if (load) m_c = int'(data) < lim ? int'(data) : lim;
    else if (os && start) begin
      m_c = up_down ? 0 : lim;
      m_ph = 1;
    end else if (enable && s != 0 && (!os || r == 1)) begin
      t = up_down ? m_c + s : m_c - s;
      if (m_c > lim) m_c = lim;
      else if (t >= 0 && t <= lim) m_c = t;
      else if (os) begin
        m_c = t < 0 ? 0 : lim;
        m_t = 1;
        m_ph = 2;
      end else if (mode == 2'b01) begin
        r = t < 0 ? 0 : lim;
        m_t = r != m_c;
        m_c = r;
      end else begin
        m_c = t < 0 ? lim : 0;
        m_t = 1;
      end
    end
  endtask
  task automatic tick();
    exp_t e;
    @(posedge clk);
    model();
    e.c = m_c;
    e.t = m_t;
    e.b = m_ph == 1;
    e.d = m_ph == 2;
    sb.push_back(e);
    @(negedge clk);
    reset = 1'b0;
    load = 1'b0;
    start = 1'b0;
    enable = 1'b0;
  endtask
  task automatic en(int n);
    for (int i = 0; i < n; i++) begin
      enable = 1'b1;
      tick();
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        compared++;
        if (int'(count) != e.c || tc !== e.t || busy !== e.b || done !== e.d) begin
          mismatched++;
          $display("FAIL cycle_check t=%0t: got count=%0d tc=%b busy=%b done=%b, expected count=%0d tc=%b busy=%b done=%b",
                   $time, count, tc, busy, done, e.c, e.t, e.b, e.d);
        end
      end
    end
  end
  initial begin
    tick();
    mode = 2'b10; limit = 9; up_down = 1'b1; step = 1;
    start = 1'b1; tick();
    load = 1'b1; data = 5; tick();
    reset = 1'b1; tick();
    mode = 2'b00; limit = 9; step = 3; load = 1'b1; data = 0; tick();
    en(4);
    up_down = 1'b0; step = 2; load = 1'b1; data = 1; tick();
    en(2);
    mode = 2'b01; limit = 200; step = 15; up_down = 1'b1; load = 1'b1; data = 190; tick();
    en(3);
    load = 1'b1; data = 250; tick();
    mode = 2'b10; limit = 4; step = 1; start = 1'b1; tick();
    en(6);
    start = 1'b1; tick();
    limit = 9; load = 1'b1; start = 1'b1; enable = 1'b1; data = 7; tick();
    limit = 3; en(1);
    mode = 2'b00; limit = 0; step = 5; en(3);
    up_down = 1'b0; en(2);
    mode = 2'b01; limit = 8'hff; up_down = 1'b1; step = 15; load = 1'b1; data = 8'hf5; tick();
    en(2);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 3))
          0: limit = '0;
          1: limit = '1;
          2: limit = 8'($urandom_range(0, 20));
          default: limit = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 9) == 0) up_down = 1'($urandom_range(0, 1));
      reset = $urandom_range(0, 99) == 0;
      load = $urandom_range(0, 15) == 0;
      start = $urandom_range(0, 11) == 0;
      enable = $urandom_range(0, 3) != 0;
      data = 8'($urandom_range(0, 255));
      step = 4'($urandom_range(0, 15));
      tick();
    end
    repeat (3) @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
